// File: rtl/debug_display_pkg.sv
// Shared constants and the hex-to-seven-segment table for the debug display.
// Optional feature macro used by the top: DEBUG_DISPLAY_LEADING_ZERO_BLANK_EN.
`ifndef DEBUG_DISPLAY_PKG_SV
`define DEBUG_DISPLAY_PKG_SV
package debug_display_pkg;
    localparam int DATA_W    = 32;
    localparam int HALF_W    = 16;
    localparam int SEG_W     = 7;
    localparam int DIGITS    = 4;

    localparam int SRC_PC    = 0;
    localparam int SRC_ALU   = 1;
    localparam int SRC_R2    = 2;
    localparam int SRC_R3    = 3;
    localparam int SRC_R4    = 4;
    localparam int SRC_COUNT = 5;
    localparam int SRC_W     = 3;

    typedef logic [SRC_W-1:0] srcIdx_t;

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [SEG_W-1:0] hexToSegments(input logic [3:0] nibble);
        logic [SEG_W-1:0] seg;
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction
endpackage
`endif

// File: rtl/debug_display_if.sv
// Observation bus from the microprocessor top into the debug display.
interface debug_display_if;
    import debug_display_pkg::*;
    logic [DATA_W-1:0] programCounter;
    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] r2;
    logic [DATA_W-1:0] r3;
    logic [DATA_W-1:0] r4;

    modport master (output programCounter, aluResult, r2, r3, r4);
    modport slave  (input  programCounter, aluResult, r2, r3, r4);
endinterface

// File: rtl/debug_display_button_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, debounced level,
// and a one-cycle pulse on the cycle the debounced level rises.
module button_debouncer
    import debug_display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic rawIn,
    output logic rise
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          synced;
    logic          level;
    logic [CW-1:0] count;

    assign synced = sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            count <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], rawIn};
            if (synced == level) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                level <= synced;
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    // Fires on the same edge that level takes the new value, so the consumer
    // acts DEBOUNCE_CYCLES+2 cycles after a clean press.
    assign rise = synced && !level && (count == CNT_LAST);
endmodule

// File: rtl/debug_display.sv
// Multiplexed 4-digit hex viewer for one of five 32-bit observation words.
// Build option: define DEBUG_DISPLAY_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module debug_display
    import debug_display_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 reset,
    debug_display_if.slave       obs,
    input  logic                 nextButton,
    input  logic                 upperHalf,
    output logic [SEG_W-1:0]     segments,
    output logic [DIGITS-1:0]    anodes,
    output logic [SRC_COUNT-1:0] sourceLeds
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST    = PW'(SCAN_DIV - 1);
    localparam logic [1:0]    DIGIT_LAST = 2'(DIGITS - 1);

    logic [PW-1:0]                   prescaler;
    logic [1:0]                      digit, digitNext;
    logic [HALF_W-1:0]               shadow, shadowNext, selHalf;
    srcIdx_t                         source;
    logic [1:0]                      upperSync;
    logic                            advance, terminal, frameEnd;
    logic [SRC_COUNT-1:0][DATA_W-1:0] words;
    logic [DATA_W-1:0]               selWord;
    logic [DIGITS-1:0]               anodesNext;
    logic [SEG_W-1:0]                segmentsNext;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) nextDebounce (
        .clk   (clk),
        .reset (reset),
        .rawIn (nextButton),
        .rise  (advance)
    );

    assign words   = {obs.r4, obs.r3, obs.r2, obs.aluResult, obs.programCounter};
    assign selWord = words[source];
    assign selHalf = upperSync[1] ? selWord[DATA_W-1:HALF_W] : selWord[HALF_W-1:0];

    // Outputs are registered from next-state digit/shadow so segments and
    // anodes always switch together on the same edge as the digit.
    always_comb begin
        terminal     = (prescaler == PS_LAST);
        frameEnd     = terminal && (digit == DIGIT_LAST);
        digitNext    = terminal ? digit + 2'd1 : digit;
        shadowNext   = frameEnd ? selHalf : shadow;
        segmentsNext = hexToSegments(shadowNext[4*digitNext +: 4]);
        anodesNext   = ~(DIGITS'(1) << digitNext);
`ifdef DEBUG_DISPLAY_LEADING_ZERO_BLANK_EN
        for (int n = 1; n < DIGITS; n++) begin
            if (digitNext == 2'(n) && (shadowNext >> (4*n)) == '0)
                anodesNext = '1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            digit     <= '0;
            shadow    <= '0;
            source    <= srcIdx_t'(SRC_PC);
            upperSync <= '0;
            segments  <= hexToSegments(4'h0);
            anodes    <= ~DIGITS'(1);
        end else begin
            prescaler <= terminal ? '0 : prescaler + PW'(1);
            digit     <= digitNext;
            shadow    <= shadowNext;
            upperSync <= {upperSync[0], upperHalf};
            segments  <= segmentsNext;
            anodes    <= anodesNext;
            // A press landing on the capture edge only affects the next frame.
            if (advance)
                source <= (source == srcIdx_t'(SRC_COUNT - 1)) ? srcIdx_t'(SRC_PC)
                                                               : source + srcIdx_t'(1);
        end
    end

    assign sourceLeds = SRC_COUNT'(1) << source;
endmodule

// File: tb/tb_debug_display.sv
// Scoreboard bench for debug_display with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
`timescale 1ns/1ps
module tb_debug_display;
    logic       clk = 1'b0;
    logic       reset;
    logic       nextButton;
    logic       upperHalf;
    logic [6:0] segments;
    logic [3:0] anodes;
    logic [4:0] sourceLeds;

    debug_display_if obs();

    debug_display #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .obs        (obs),
        .nextButton (nextButton),
        .upperHalf  (upperHalf),
        .segments   (segments),
        .anodes     (anodes),
        .sourceLeds (sourceLeds)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; frame f slot k is visible for cyc in 16f+4k .. 16f+4k+3
    int cyc = 0;
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    typedef struct {
        int         at;
        logic [3:0] an;
        logic [6:0] seg;
        bit         chkSeg;
        logic [4:0] leds;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   vectors = 0;
    int   miscompares = 0;
    bit   armed = 1'b0;

    logic [6:0] segTab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    task automatic expSlot(input int at, input logic [15:0] shadow, input int slot,
                           input logic [4:0] leds, input string tag);
        exp_t e;
        bit   blank;
        blank = 1'b0;
`ifdef DEBUG_DISPLAY_LEADING_ZERO_BLANK_EN
        if (slot > 0 && (shadow >> (4*slot)) == 16'h0) blank = 1'b1;
`endif
        e.at     = at;
        e.an     = blank ? 4'b1111 : ~(4'b0001 << slot);
        e.seg    = segTab[shadow[4*slot +: 4]];
        e.chkSeg = !blank;
        e.leds   = leds;
        e.name   = $sformatf("%s@%0d", tag, at);
        sb.push_back(e);
    endtask

    // Monitor: pops every expectation whose cycle has been reached
    initial forever begin
        @(negedge clk);
        if (armed) begin
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                m = sb.pop_front();
                vectors++;
                if (anodes !== m.an || sourceLeds !== m.leds || (m.chkSeg && segments !== m.seg)) begin
                    miscompares++;
                    $display("FAIL %s: got anodes=%b segments=%b leds=%b, want anodes=%b segments=%b leds=%b",
                             m.name, anodes, segments, sourceLeds, m.an, m.seg, m.leds);
                end
            end
        end
    end

    task automatic atCyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic press(input int a);
        atCyc(a);
        nextButton = 1'b1;
        atCyc(a + 12);
        nextButton = 1'b0;
    endtask

    task automatic drainCheck(input string tag);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain-%s: %0d expectations left, want 0", tag, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs.programCounter = 32'h0000_1234;
        obs.aluResult      = 32'h0000_0005;
        obs.r2             = 32'hABCD_0000;
        obs.r3             = 32'h1111_2222;
        obs.r4             = 32'h5566_7788;
        reset      = 1'b1;
        nextButton = 1'b0;
        upperHalf  = 1'b0;
        @(posedge clk);
        expSlot(0, 16'h0000, 0, 5'b00001, "reset");
        armed = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        expSlot(  1, 16'h0000, 0, 5'b00001, "f0");
        expSlot(  5, 16'h0000, 1, 5'b00001, "f0");
        expSlot( 15, 16'h0000, 3, 5'b00001, "f0");
        expSlot( 17, 16'h1234, 0, 5'b00001, "pc");
        expSlot( 21, 16'h1234, 1, 5'b00001, "pc");
        expSlot( 25, 16'h1234, 2, 5'b00001, "pc");
        expSlot( 29, 16'h1234, 3, 5'b00001, "pc");
        expSlot( 55, 16'h1234, 1, 5'b00001, "bouncePre");
        expSlot( 56, 16'h1234, 2, 5'b00010, "bounceAdv");
        expSlot( 65, 16'h0005, 0, 5'b00010, "alu");
        expSlot( 69, 16'h0005, 1, 5'b00010, "alu");
        expSlot( 77, 16'h0005, 3, 5'b00010, "alu");
        expSlot( 95, 16'h0005, 3, 5'b00010, "shortPulse");
        expSlot(105, 16'h0005, 2, 5'b00010, "p1pre");
        expSlot(106, 16'h0005, 2, 5'b00100, "p1");
        expSlot(129, 16'h0000, 0, 5'b00100, "p2pre");
        expSlot(130, 16'h0000, 0, 5'b01000, "p2");
        expSlot(153, 16'h2222, 2, 5'b01000, "p3pre");
        expSlot(154, 16'h2222, 2, 5'b10000, "p3");
        expSlot(161, 16'h7788, 0, 5'b10000, "r4");
        expSlot(173, 16'h7788, 3, 5'b10000, "r4");
        expSlot(177, 16'h7788, 0, 5'b10000, "p4pre");
        expSlot(178, 16'h7788, 0, 5'b00001, "p4wrap");
        expSlot(201, 16'h1234, 2, 5'b00001, "p5pre");
        expSlot(202, 16'h1234, 2, 5'b00010, "p5");
        expSlot(225, 16'h0005, 0, 5'b00010, "p6pre");
        expSlot(226, 16'h0005, 0, 5'b00100, "p6");
        expSlot(241, 16'hABCD, 0, 5'b00100, "upper");
        expSlot(245, 16'hABCD, 1, 5'b00100, "upper");
        expSlot(249, 16'hABCD, 2, 5'b00100, "upper");
        expSlot(253, 16'hABCD, 3, 5'b00100, "upper");
        expSlot(261, 16'hABCD, 1, 5'b00100, "upperHold");
        expSlot(273, 16'h0000, 0, 5'b00100, "lower");
        expSlot(277, 16'h0000, 1, 5'b00100, "lower");
        expSlot(287, 16'h0000, 3, 5'b00100, "capPre");
        expSlot(288, 16'h0000, 0, 5'b01000, "capOldSrc");
        expSlot(305, 16'h2222, 0, 5'b01000, "capNewSrc");
        expSlot(309, 16'h2222, 1, 5'b01000, "capNewSrc");

        // Bounce: toggle every 2 cycles for 12 cycles, then hold 12
        for (int i = 0; i < 12; i++) begin
            atCyc(34 + i);
            nextButton = ((i / 2) % 2) == 0;
        end
        press(46);
        // 6-cycle pulse is too short to be accepted
        atCyc(80);
        nextButton = 1'b1;
        atCyc(86);
        nextButton = 1'b0;
        for (int k = 0; k < 5; k++) press(96 + 24*k);
        press(216);
        atCyc(230);
        upperHalf = 1'b1;
        atCyc(258);
        upperHalf = 1'b0;
        press(278);   // lands on the capture edge at 288

        atCyc(314);
        drainCheck("phase1");

        // Mid-frame reset with the button held through it
        reset      = 1'b1;
        nextButton = 1'b1;
        @(posedge clk);
        expSlot(0, 16'h0000, 0, 5'b00001, "midReset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        expSlot( 5, 16'h0000, 1, 5'b00001, "r");
        expSlot( 9, 16'h0000, 2, 5'b00001, "heldPre");
        expSlot(10, 16'h0000, 2, 5'b00010, "heldAdv");
        expSlot(17, 16'h0005, 0, 5'b00010, "r");
        expSlot(21, 16'h0005, 1, 5'b00010, "r");
        atCyc(20);
        nextButton = 1'b0;
        atCyc(24);
        drainCheck("phase2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
